// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch PC, synchronous instruction ROM and a small fetch
// queue feeding decode over valid/ready. Redirects flush the queue and restart
// fetch at the new PC.
//
// Optional feature macro: IFU_PERF_CNT_EN. When it is defined, the delivered
// instruction counter and the stall counter are built. When it is undefined,
// both counter outputs are tied to 0.
//
// Handshake: a word moves to decode on every rising edge where
// inst_valid && inst_ready. inst_valid never depends on inst_ready. A redirect
// on the same edge still completes the transfer from decode's point of view,
// but it flushes the queue.
//
// ROM contents: the surrounding environment preloads rom_mem.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 256,
  parameter int          Q_DEPTH    = 2,
  parameter string       IMEM_FILE  = "imem.hex"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_vld,
  input  logic [31:0] redirect_pc,
  input  logic        inst_ready,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int QW = $clog2(Q_DEPTH);
  localparam int CW = QW + 1;

  // Instruction ROM; read address is registered through the queue write.
  logic [31:0] rom_mem [IMEM_DEPTH];

  // Fetch queue storage and pointers.
  logic [31:0]   q_inst_q [Q_DEPTH];
  logic [31:0]   q_inst_d [Q_DEPTH];
  logic [31:0]   q_pc_q   [Q_DEPTH];
  logic [31:0]   q_pc_d   [Q_DEPTH];
  logic [QW-1:0] rd_q, rd_d;
  logic [QW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;

  logic          q_empty;
  logic          q_full;
  logic          pop;
  logic          issue;
  logic [IW-1:0] rom_idx;
  logic [31:0]   rom_rdata;

  // The low two bits of the redirect target are ignored because targets are word aligned.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Queue status, handshake and issue decision.
  always_comb begin
    q_empty   = (cnt_q == '0);
    q_full    = (cnt_q == CW'(Q_DEPTH));
    pop       = !q_empty && inst_ready;
    issue     = !redirect_vld && (!q_full || pop);
    rom_idx   = fetch_pc_q[IW+1:2];
    rom_rdata = rom_mem[rom_idx];
  end

  // Next-state for queue, pointers and fetch PC; a redirect overrides issue and pop.
  always_comb begin
    q_inst_d   = q_inst_q;
    q_pc_d     = q_pc_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_vld) begin
      rd_d       = '0;
      wr_d       = '0;
      cnt_d      = '0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else begin
      if (issue) begin
        q_inst_d[wr_q] = rom_rdata;
        q_pc_d[wr_q]   = fetch_pc_q;
        wr_d           = wr_q + 1'b1;
        fetch_pc_d     = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_d = rd_q + 1'b1;
      end
      cnt_d = cnt_q + CW'(issue) - CW'(pop);
    end
  end

  // State registers; reset empties the queue and zeroes every entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Q_DEPTH; i++) begin
        q_inst_q[i] <= '0;
        q_pc_q[i]   <= '0;
      end
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      fetch_pc_q <= RESET_PC;
    end else begin
      q_inst_q   <= q_inst_d;
      q_pc_q     <= q_pc_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Decode-facing outputs come straight from the queue head.
  always_comb begin
    inst_valid = !q_empty;
    inst_out   = q_inst_q[rd_q];
    inst_pc    = q_pc_q[rd_q];
    inst_pc4   = q_pc_q[rd_q] + 32'd4;
    fetch_pc   = fetch_pc_q;
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Performance counters. A pop on a redirect edge is not counted as a delivery.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (pop && !redirect_vld) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (inst_valid && !inst_ready) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter registers; only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign fetch_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit. It uses a queue-of-PCs reference model plus a
// mirrored ROM image.
module tb_instr_fetch_unit;

  localparam int IMEM_DEPTH = 256;
  localparam int Q_DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_vld;
  logic [31:0] redirect_pc;
  logic        inst_ready;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_DEPTH (IMEM_DEPTH),
    .Q_DEPTH    (Q_DEPTH),
    .IMEM_FILE  ("")
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .redirect_vld (redirect_vld),
    .redirect_pc  (redirect_pc),
    .inst_ready   (inst_ready),
    .inst_valid   (inst_valid),
    .inst_out     (inst_out),
    .inst_pc      (inst_pc),
    .inst_pc4     (inst_pc4),
    .fetch_pc     (fetch_pc),
    .fetch_cnt    (fetch_cnt),
    .stall_cnt    (stall_cnt)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Reference model state: the PCs expected in the queue, in delivery order.
  logic [31:0] rom_model [IMEM_DEPTH];
  logic [31:0] exp_q [$];
  logic [31:0] m_pc;
  logic [31:0] m_fetch_cnt;
  logic [31:0] m_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rom_at(input logic [31:0] pc);
    return rom_model[(pc >> 2) % IMEM_DEPTH];
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pc        = 32'h0;
    m_fetch_cnt = 32'h0;
    m_stall_cnt = 32'h0;
  endtask

  task automatic check_outputs(input string ph);
    logic [31:0] hpc;
    chk({ph, ":inst_valid"}, 32'(inst_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      hpc = exp_q[0];
      chk({ph, ":inst_pc"}, inst_pc, hpc);
      chk({ph, ":inst_pc4"}, inst_pc4, hpc + 32'd4);
      chk({ph, ":inst_out"}, inst_out, rom_at(hpc));
    end
    chk({ph, ":fetch_pc"}, fetch_pc, m_pc);
`ifdef IFU_PERF_CNT_EN
    chk({ph, ":fetch_cnt"}, fetch_cnt, m_fetch_cnt);
    chk({ph, ":stall_cnt"}, stall_cnt, m_stall_cnt);
`else
    chk({ph, ":fetch_cnt"}, fetch_cnt, 32'h0);
    chk({ph, ":stall_cnt"}, stall_cnt, 32'h0);
`endif
  endtask

  // Driver for one clock: apply the inputs, advance the model across the edge, then check.
  task automatic step(input string ph, input logic rv, input logic [31:0] rpc, input logic rdy);
    bit valid;
    bit do_pop;
    bit room;
    redirect_vld = rv;
    redirect_pc  = rpc;
    inst_ready   = rdy;
    @(posedge clk);
    valid  = exp_q.size() > 0;
    do_pop = valid && rdy;
    room   = (exp_q.size() < Q_DEPTH) || do_pop;
    if (valid && !rdy) m_stall_cnt++;
    if (rv) begin
      exp_q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (do_pop) begin
        void'(exp_q.pop_front());
        m_fetch_cnt++;
      end
      if (room) begin
        exp_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
    check_outputs(ph);
  endtask

  initial begin
    rst          = 1'b0;
    redirect_vld = 1'b0;
    redirect_pc  = 32'h0;
    inst_ready   = 1'b0;
    for (int i = 0; i < IMEM_DEPTH; i++) begin
      rom_model[i]    = $urandom;
      dut.rom_mem[i]  = rom_model[i];
    end
    model_reset();

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst:inst_valid", 32'(inst_valid), 32'h0);
    chk("rst:inst_out", inst_out, 32'h0);
    chk("rst:inst_pc", inst_pc, 32'h0);
    chk("rst:inst_pc4", inst_pc4, 32'h4);
    chk("rst:fetch_pc", fetch_pc, 32'h0);
    chk("rst:fetch_cnt", fetch_cnt, 32'h0);
    chk("rst:stall_cnt", stall_cnt, 32'h0);
    rst = 1'b1;

    // Streaming with ready held high: A0..A3 on consecutive edges.
    step("t1a", 1'b0, 32'h0, 1'b1);
    chk("t1:first_pc", inst_pc, 32'h0);
    chk("t1:first_inst", inst_out, rom_model[0]);
    for (int i = 0; i < 3; i++) step("t1", 1'b0, 32'h0, 1'b1);
    chk("t1:fourth_pc", inst_pc, 32'hC);
    chk("t1:fourth_inst", inst_out, rom_model[3]);

    // Back-pressure for 5 cycles, then drain.
    for (int i = 0; i < 5; i++) step("t2_stall", 1'b0, 32'h0, 1'b0);
    chk("t2:fetch_pc_held", fetch_pc, 32'h10 + 32'(4 * (Q_DEPTH - 1)));
    for (int i = 0; i < 2; i++) step("t2_drain", 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) step("t2_stall2", 1'b0, 32'h0, 1'b0);

    // Redirect while the queue is full.
    step("t3_redir", 1'b1, 32'h42, 1'b0);
    chk("t3:valid_gap", 32'(inst_valid), 32'h0);
    chk("t3:fetch_pc", fetch_pc, 32'h40);
    step("t3_target", 1'b0, 32'h0, 1'b0);
    chk("t3:target_pc", inst_pc, 32'h40);
    chk("t3:target_inst", inst_out, rom_model[16]);
    step("t3_run", 1'b0, 32'h0, 1'b1);

    // Redirect coinciding with a pop, then a second redirect.
    step("t4_r1", 1'b1, 32'h20, 1'b1);
    step("t4_r2", 1'b1, 32'h80, 1'b1);
    for (int i = 0; i < 4; i++) step("t4_run", 1'b0, 32'h0, 1'b1);

    // ROM index wrap and 32-bit PC wrap.
    step("t5_r", 1'b1, 32'h3F4, 1'b1);
    for (int i = 0; i < 6; i++) step("t5_run", 1'b0, 32'h0, 1'b1);
    step("t5_r2", 1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 5; i++) step("t5_wrap", 1'b0, 32'h0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic        rv;
      logic [31:0] rpc;
      rv  = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                        : 32'($urandom_range(0, 16'hFFFF));
      step("rand", rv, rpc, ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset while the queue holds words.
    for (int i = 0; i < 3; i++) step("t6_fill", 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("t6:valid_async", 32'(inst_valid), 32'h0);
    chk("t6:fetch_pc", fetch_pc, 32'h0);
    chk("t6:fetch_cnt", fetch_cnt, 32'h0);
    chk("t6:stall_cnt", stall_cnt, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step("t6_restart", 1'b0, 32'h0, 1'b1);
    chk("t6:restart_inst", inst_out, rom_model[0]);
    for (int i = 0; i < 4; i++) step("t6_run", 1'b0, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
